// File: rtl/board_match_scanner_pkg.sv
// board_match_scanner_pkg: shared board geometry, colour constants, cell indexing and scan states
package board_match_scanner_pkg;
    localparam int N       = 8;
    localparam int CW      = 3;
    localparam int MIN_RUN = 3;
    localparam int IW      = $clog2(N);
    localparam int KW      = $clog2(N * N + 1);
    localparam logic [CW-1:0] COLOR_EMPTY = CW'(0);
    localparam logic [CW-1:0] COLOR_MIN   = CW'(1);
    localparam logic [CW-1:0] COLOR_MAX   = CW'(6);
    typedef enum logic [1:0] {IDLE, SCAN_ROW, SCAN_COL, DONE} scan_state_t;
    function automatic int cell_idx(input int r, input int c);
        return N * r + c;
    endfunction
endpackage

// File: rtl/board_match_scanner_line_match.sv
// line_match: flags every cell of a line lying in a run of at least MIN_RUN equal non-empty colours
module line_match
    import board_match_scanner_pkg::*;
(
    input  logic [N-1:0][CW-1:0] line,
    output logic [N-1:0]         mask
);
    logic [N-MIN_RUN:0] win;
    // a window of MIN_RUN equal non-empty cells marks all its cells; overlapping windows cover longer runs whole
    always_comb begin
        win  = '0;
        mask = '0;
        for (int s = 0; s <= N - MIN_RUN; s++) begin
            win[s] = line[s] != COLOR_EMPTY;
            for (int k = 1; k < MIN_RUN; k++) win[s] = win[s] & (line[s+k] == line[s]);
            for (int k = 0; k < MIN_RUN; k++) if (win[s]) mask[s+k] = 1'b1;
        end
    end
endmodule

// File: rtl/board_match_scanner.sv
// board_match_scanner: scans a captured board one row then one column per cycle for match runs (optional MATCH_CNT_EN adds the match counter)
module board_match_scanner
    import board_match_scanner_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*N*CW-1:0] board_in,
    input  logic              board_valid,
    output logic              busy,
    output logic              done,
    output logic [N*N-1:0]    match_mask,
    output logic              has_match,
    output logic [KW-1:0]     match_cnt
);
    scan_state_t state, state_n;
    logic [IW-1:0]       idx;
    logic [N*N*CW-1:0]   board_q;
    logic [N-1:0][CW-1:0] line;
    logic [N-1:0]        line_mask;
    logic [N*N-1:0]      spread;
    logic                accept, scanning, last;
    assign accept   = (state == IDLE || state == DONE) && board_valid;
    assign scanning = state == SCAN_ROW || state == SCAN_COL;
    assign last     = idx == IW'(N - 1);
    assign busy     = scanning;
    assign done     = state == DONE;
    assign has_match = |match_mask;
    // pick the current row or column and map its run mask back onto board positions
    always_comb begin
        spread = '0;
        for (int k = 0; k < N; k++) begin
            line[k] = state == SCAN_COL ? board_q[cell_idx(k, int'(idx))*CW +: CW]
                                        : board_q[cell_idx(int'(idx), k)*CW +: CW];
            spread[state == SCAN_COL ? cell_idx(k, int'(idx)) : cell_idx(int'(idx), k)] = line_mask[k];
        end
    end
    line_match u_line (
        .line (line),
        .mask (line_mask)
    );
    // next-state logic: rows, then columns, then a one-cycle done that can directly accept a new board
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = board_valid ? SCAN_ROW : IDLE;
            SCAN_ROW:   state_n = last ? SCAN_COL : SCAN_ROW;
            SCAN_COL:   state_n = last ? DONE : SCAN_COL;
            default:    state_n = IDLE;
        endcase
    end
    // state, line index, captured board and accumulated mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            board_q    <= '0;
            match_mask <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                board_q    <= board_in;
                idx        <= '0;
                match_mask <= '0;
            end else if (scanning) begin
                idx        <= last ? '0 : idx + 1'b1;
                match_mask <= match_mask | spread;
            end
        end
    end
`ifdef MATCH_CNT_EN
    logic [KW-1:0] cnt_q;
    // count only cells newly added to the mask so row/column overlaps are counted once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (accept) cnt_q <= '0;
        else if (scanning) cnt_q <= cnt_q + KW'($countones(spread & ~match_mask));
    end
    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif
endmodule

// File: doc/board_match_scanner.md
# board_match_scanner

Consumes the packed 8×8 colour board produced by the board generator and scans it for match-3 runs. It flags every cell belonging to a horizontal or vertical run of at least MIN_RUN equal non-empty colours, and reports a 64-bit clear mask and a match count. It sits between the generator or board register and the elimination/refill logic. It scans one line per cycle under a valid/busy/done handshake.

## Interface
- N, 8, board side length in cells (rows = columns = N)
- CW, 3, bits per cell colour; colour 0 = empty, 1..6 = valid colours
- MIN_RUN, 3, minimum equal-colour run length that counts as a match
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- board_in  in  N\*N\*CW (192)  packed board; cell (r,c) at bits [(N\*r+c)\*CW +: CW]
- board_valid  in  1  request to scan board_in; sampled on rising clk
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse; results valid from this cycle
- match_mask  out  N\*N (64)  bit N\*r+c set if cell (r,c) is in any run
- has_match  out  1  match_mask != 0
- match_cnt  out  7  popcount of match_mask (0..64)

## Operation
- States: IDLE, SCAN_ROW, SCAN_COL, DONE.
- IDLE or DONE with board_valid=1: capture board_in into an internal register, clear mask and count, index←0, go to SCAN_ROW.
- SCAN_ROW: extract row[index] and run line match. Set mask |= line mask at the row positions. At index=N-1, go to SCAN_COL with index←0; otherwise index+1.
- SCAN_COL: same operation on column[index], with bits at positions N\*k+index. At index=N-1, go to DONE.
- DONE: done=1 for one cycle, then IDLE unless a new board_valid is accepted.
- Line match rule:
  - A maximal run of ≥MIN_RUN consecutive equal colours, all ≠0, sets every cell of that run.
  - Runs of length ≥MIN_RUN are marked whole.
  - Runs of empty cells (colour 0) never match.
- Overlapping row/column hits on the same cell count once.
- match_cnt adds popcount(line_mask & ~mask_so_far) each scan cycle.
- board_valid while busy (SCAN_ROW/SCAN_COL) is ignored. The captured board is not disturbed.
- Outputs match_mask, has_match and match_cnt hold their last result until the next accepted board_valid. They are cleared in the capture cycle.

## Timing
- Reset values: state IDLE, busy=0, done=0, match_mask=0, has_match=0, match_cnt=0, index=0.
- board_valid is sampled high at edge E. busy=1 from E through the last scan edge. Scanning takes 2N=16 cycles. done=1 in the cycle after E+16, so done is visible 17 cycles after E. busy=0 in DONE.
- Back-to-back operation: board_valid sampled during DONE starts a new scan with no idle bubble.
- Reset asserted mid-scan: immediate abort, all outputs return to reset values, no done pulse.
- board_in need only be stable at the accepting edge.

## Configuration
- MATCH_CNT_EN defined: the match_cnt accumulator and popcount logic are present, as described above.
- MATCH_CNT_EN undefined: match_cnt is tied to 0 and no accumulator is built. match_mask, has_match and the handshake are unchanged.

## Structure
- Shared package: N, CW, MIN_RUN, colour constants (COLOR_EMPTY=0, COLOR_MIN=1, COLOR_MAX=6), cell-index helper, and the scan state enum.
- Sub-module line_match: combinational, N×CW colours in, N-bit run mask out. Shared by the row and column phases through a mux on the extracted line.

## Test plan
In these tests, "background" means colour 1+((r+c) mod 2), which contains no runs.
- Background only, board_valid pulse → done 17 cycles later, match_mask=0, has_match=0, match_cnt=0.
- Background with row 0 cols 0..2 set to 5 → match_mask=0x0000000000000007, match_cnt=3.
- Background with column 7 all set to 4 → match_mask=0x8080808080808080, match_cnt=8.
- Background with row 3 cols 2..4 and col 3 rows 2..4 set to 6 → mask bits {19,26,27,28,35} set, match_cnt=5 (cell 27 counted once).
- Row 0 all set to 0, rest background → no match. A board_valid with a different board applied at scan cycle 4 is ignored; the result reflects the first board.
- rst_n pulled low at scan cycle 5 → busy=0, mask=0, no done. A fresh board_valid after release → normal done after 17 cycles. A second board_valid in the DONE cycle → a new scan starts immediately.
